// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store memory controller: state encoding,
// memop (funct3) codes, base strobe masks and legality checks.
package lsu_mem_ctrl_pkg;

   localparam int XLEN   = 64;
   localparam int STRB_W = XLEN / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   localparam logic [2:0] MEMOP_LB  = 3'b000;
   localparam logic [2:0] MEMOP_LH  = 3'b001;
   localparam logic [2:0] MEMOP_LW  = 3'b010;
   localparam logic [2:0] MEMOP_LD  = 3'b011;
   localparam logic [2:0] MEMOP_LBU = 3'b100;
   localparam logic [2:0] MEMOP_LHU = 3'b101;
   localparam logic [2:0] MEMOP_LWU = 3'b110;
   localparam logic [2:0] MEMOP_SB  = 3'b000;
   localparam logic [2:0] MEMOP_SH  = 3'b001;
   localparam logic [2:0] MEMOP_SW  = 3'b010;
   localparam logic [2:0] MEMOP_SD  = 3'b011;

   localparam logic [STRB_W-1:0] STRB_B = 8'h01;
   localparam logic [STRB_W-1:0] STRB_H = 8'h03;
   localparam logic [STRB_W-1:0] STRB_W_MASK = 8'h0F;
   localparam logic [STRB_W-1:0] STRB_D = 8'hFF;

   // memop[1:0] encodes the access size for both loads and stores
   function automatic logic [STRB_W-1:0] base_strb(input logic [1:0] size);
      case (size)
         2'd0:    return STRB_B;
         2'd1:    return STRB_H;
         2'd2:    return STRB_W_MASK;
         default: return STRB_D;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return off[0];
         2'd2:    return |off[1:0];
         default: return |off;
      endcase
   endfunction

   function automatic logic is_illegal(input logic we, input logic [2:0] memop);
      return we ? memop[2] : (memop == 3'b111);
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Handshaked 64-bit data-memory bus between the load/store controller and memory.
interface lsu_mem_ctrl_if;
   import lsu_mem_ctrl_pkg::*;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_we;
   logic [XLEN-1:0]   mem_req_addr;
   logic [XLEN-1:0]   mem_req_wdata;
   logic [STRB_W-1:0] mem_req_wstrb;
   logic              mem_resp_valid;
   logic [XLEN-1:0]   mem_resp_rdata;
   logic              mem_resp_err;

   modport master (
      output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
   );

   modport slave (
      input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
   );

endinterface

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Byte-lane steering: store shift/strobes, load extract/extend, and access legality.
module lsu_lane_align
   import lsu_mem_ctrl_pkg::*;
(
   input  logic              we,
   input  logic [2:0]        memop,
   input  logic [2:0]        off,
   input  logic [XLEN-1:0]   wdata,
   input  logic [XLEN-1:0]   rdata,
   output logic [XLEN-1:0]   wdata_lane,
   output logic [STRB_W-1:0] wstrb,
   output logic [XLEN-1:0]   rdata_ext,
   output logic              bad
);

   logic [1:0]      size;
   logic [5:0]      bit_off;
   logic [XLEN-1:0] rshift;

   assign size    = memop[1:0];
   assign bit_off = {off, 3'b000};

   always_comb begin
      wdata_lane = wdata << bit_off;
      wstrb      = we ? (base_strb(size) << off) : '0;
      rshift     = rdata >> bit_off;
      // memop[2] selects the unsigned load variants
      case (size)
         2'd0:    rdata_ext = memop[2] ? {{(XLEN-8){1'b0}}, rshift[7:0]}
                                       : {{(XLEN-8){rshift[7]}}, rshift[7:0]};
         2'd1:    rdata_ext = memop[2] ? {{(XLEN-16){1'b0}}, rshift[15:0]}
                                       : {{(XLEN-16){rshift[15]}}, rshift[15:0]};
         2'd2:    rdata_ext = memop[2] ? {{(XLEN-32){1'b0}}, rshift[31:0]}
                                       : {{(XLEN-32){rshift[31]}}, rshift[31:0]};
         default: rdata_ext = rshift;
      endcase
      bad = is_illegal(we, memop) | is_misaligned(size, off);
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory controller: one bus transaction per LS request, stalling the
// pipeline until the response is returned.
//
//   state | meaning
//   IDLE  | ready; accept and classify an incoming request
//   REQ   | bus request held until mem_req_ready
//   WAIT  | request accepted; waiting for mem_resp_valid
//   RESP  | one-cycle resp_valid to LS/WB; pipeline advances
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_memop,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              req_ready,
   output logic              stall_o,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              misalign_o,
   output logic              err_o,
   lsu_mem_ctrl_if.master    mem
);

   lsu_state_e state_q, state_d;

   logic            we_q;
   logic [2:0]      memop_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] rdata_q;
   logic            misalign_q;
   logic            err_q;

   logic              sel_we;
   logic [2:0]        sel_memop;
   logic [2:0]        sel_off;
   logic [XLEN-1:0]   sel_wdata;
   logic [XLEN-1:0]   lane_wdata;
   logic [STRB_W-1:0] lane_wstrb;
   logic [XLEN-1:0]   lane_rdata;
   logic              lane_bad;
   logic              accept;

   assign accept = (state_q == ST_IDLE) && req_valid;

   // Classify the live request in IDLE; afterwards steer lanes from the latched copy.
   always_comb begin
      sel_we    = we_q;
      sel_memop = memop_q;
      sel_off   = addr_q[2:0];
      sel_wdata = wdata_q;
      if (state_q == ST_IDLE) begin
         sel_we    = req_we;
         sel_memop = req_memop;
         sel_off   = req_addr[2:0];
         sel_wdata = req_wdata;
      end
   end

   lsu_lane_align u_lane_align (
      .we         (sel_we),
      .memop      (sel_memop),
      .off        (sel_off),
      .wdata      (sel_wdata),
      .rdata      (mem.mem_resp_rdata),
      .wdata_lane (lane_wdata),
      .wstrb      (lane_wstrb),
      .rdata_ext  (lane_rdata),
      .bad        (lane_bad)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         memop_q    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            we_q    <= req_we;
            memop_q <= req_memop;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (accept && lane_bad) begin
            rdata_q    <= '0;
            misalign_q <= 1'b1;
            err_q      <= 1'b0;
         end else if ((state_q == ST_WAIT) && mem.mem_resp_valid) begin
            rdata_q    <= (mem.mem_resp_err || we_q) ? '0 : lane_rdata;
            misalign_q <= 1'b0;
            err_q      <= mem.mem_resp_err;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = lane_bad ? ST_RESP : ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem.mem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem.mem_resp_valid) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready         = (state_q == ST_IDLE);
      stall_o           = accept || (state_q == ST_REQ) || (state_q == ST_WAIT);
      resp_valid        = (state_q == ST_RESP);
      resp_rdata        = rdata_q;
      misalign_o        = misalign_q;
      err_o             = err_q;
      mem.mem_req_valid = (state_q == ST_REQ);
      mem.mem_req_we    = we_q;
      mem.mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
      mem.mem_req_wdata = (state_q == ST_REQ) ? lane_wdata : '0;
      mem.mem_req_wstrb = (state_q == ST_REQ) ? lane_wstrb : '0;
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: store lanes, load extension, misalignment,
// bus stall/error and reset abandonment.
module tb_lsu_mem_ctrl;
   import lsu_mem_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_memop;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        req_ready;
   logic        stall_o;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        misalign_o;
   logic        err_o;

   lsu_mem_ctrl_if bus ();

   lsu_mem_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_memop  (req_memop),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .stall_o    (stall_o),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .misalign_o (misalign_o),
      .err_o      (err_o),
      .mem        (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [63:0] g_addr, g_wdata, g_rdata;
   logic [7:0]  g_wstrb;
   logic        g_we, g_seen, g_stable, g_stall_ok, g_misalign, g_err, g_after_ok;
   int          g_resp_cyc, g_req_cyc;

   // Drives one request and plays the memory side; records what the DUT did.
   task automatic issue(input logic we, input logic [2:0] memop, input logic [63:0] addr,
                        input logic [63:0] wdata, input int ready_lat,
                        input logic [63:0] rdata, input logic err);
      logic resp_next;
      resp_next  = 1'b0;
      g_seen     = 1'b0;
      g_stable   = 1'b1;
      g_stall_ok = 1'b1;
      g_resp_cyc = -1;
      g_req_cyc  = 0;
      g_after_ok = 1'b0;
      g_addr = '0; g_wdata = '0; g_wstrb = '0; g_we = 1'b0;
      g_rdata = '0; g_misalign = 1'b0; g_err = 1'b0;
      req_valid = 1'b1; req_we = we; req_memop = memop; req_addr = addr; req_wdata = wdata;
      bus.mem_resp_rdata = rdata;
      bus.mem_resp_err   = err;
      for (int c = 0; c < 64; c++) begin
         bus.mem_req_ready  = (g_req_cyc >= ready_lat);
         bus.mem_resp_valid = resp_next;
         resp_next = 1'b0;
         #2;
         if (c == 0 && !req_ready) g_stall_ok = 1'b0;
         if (resp_valid) begin
            g_resp_cyc = c;
            g_rdata    = resp_rdata;
            g_misalign = misalign_o;
            g_err      = err_o;
            if (stall_o || req_ready) g_stall_ok = 1'b0;
            break;
         end
         if (!stall_o) g_stall_ok = 1'b0;
         if (c > 0 && req_ready) g_stall_ok = 1'b0;
         if (bus.mem_req_valid) begin
            if (!g_seen) begin
               g_seen  = 1'b1;
               g_addr  = bus.mem_req_addr;
               g_wdata = bus.mem_req_wdata;
               g_wstrb = bus.mem_req_wstrb;
               g_we    = bus.mem_req_we;
            end else if (g_addr !== bus.mem_req_addr || g_wdata !== bus.mem_req_wdata ||
                         g_wstrb !== bus.mem_req_wstrb || g_we !== bus.mem_req_we) begin
               g_stable = 1'b0;
            end
            g_req_cyc++;
            if (bus.mem_req_ready) resp_next = 1'b1;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_req_ready  = 1'b0;
      #2;
      g_after_ok = !resp_valid && req_ready && !stall_o;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_memop = '0; req_addr = '0; req_wdata = '0;
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = '0; bus.mem_resp_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall_o); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_req_valid got %b exp 0", bus.mem_req_valid); end
      checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
      checks++; if (misalign_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", misalign_o, err_o); end
      checks++; if (bus.mem_req_addr !== 64'h0 || bus.mem_req_wstrb !== 8'h0) begin errors++; $display("FAIL rst_bus got %h/%h exp 0/0", bus.mem_req_addr, bus.mem_req_wstrb); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store_sd();
      issue(1'b1, MEMOP_SD, 64'h8000_0010, 64'h1122334455667788, 0, 64'hDEADBEEFCAFEF00D, 1'b0);
      checks++; if (g_resp_cyc != 3) begin errors++; $display("FAIL sd_latency got %0d exp 3", g_resp_cyc); end
      checks++; if (g_addr !== 64'h8000_0010) begin errors++; $display("FAIL sd_addr got %h exp 80000010", g_addr); end
      checks++; if (g_wstrb !== 8'hFF) begin errors++; $display("FAIL sd_wstrb got %h exp ff", g_wstrb); end
      checks++; if (g_wdata !== 64'h1122334455667788) begin errors++; $display("FAIL sd_wdata got %h exp 1122334455667788", g_wdata); end
      checks++; if (g_we !== 1'b1) begin errors++; $display("FAIL sd_we got %b exp 1", g_we); end
      checks++; if (g_stall_ok !== 1'b1) begin errors++; $display("FAIL sd_stall got %b exp 1", g_stall_ok); end
      checks++; if (g_rdata !== 64'h0) begin errors++; $display("FAIL sd_rdata got %h exp 0", g_rdata); end
      checks++; if (g_misalign !== 1'b0 || g_err !== 1'b0) begin errors++; $display("FAIL sd_flags got %b%b exp 00", g_misalign, g_err); end
      checks++; if (g_after_ok !== 1'b1) begin errors++; $display("FAIL sd_one_pulse got %b exp 1", g_after_ok); end
   endtask

   task automatic test_err_wait();
      issue(1'b0, MEMOP_LD, 64'h8000_0020, 64'h0, 5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      checks++; if (g_resp_cyc != 8) begin errors++; $display("FAIL err_latency got %0d exp 8", g_resp_cyc); end
      checks++; if (g_req_cyc != 6) begin errors++; $display("FAIL err_req_cycles got %0d exp 6", g_req_cyc); end
      checks++; if (g_stable !== 1'b1) begin errors++; $display("FAIL err_req_stable got %b exp 1", g_stable); end
      checks++; if (g_addr !== 64'h8000_0020 || g_wstrb !== 8'h00 || g_we !== 1'b0) begin errors++; $display("FAIL err_req_fields got %h/%h/%b exp 80000020/00/0", g_addr, g_wstrb, g_we); end
      checks++; if (g_err !== 1'b1 || g_misalign !== 1'b0) begin errors++; $display("FAIL err_flags got err %b mis %b exp 1 0", g_err, g_misalign); end
      checks++; if (g_rdata !== 64'h0) begin errors++; $display("FAIL err_rdata got %h exp 0", g_rdata); end
      checks++; if (g_stall_ok !== 1'b1) begin errors++; $display("FAIL err_stall got %b exp 1", g_stall_ok); end
   endtask

   task automatic test_load_ext();
      logic [2:0]  op_t  [0:10] = '{MEMOP_LB, MEMOP_LBU, MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LH,
                                    MEMOP_LHU, MEMOP_LW, MEMOP_LWU, MEMOP_LW, MEMOP_LD};
      logic [63:0] adr_t [0:10] = '{64'h8000_0003, 64'h8000_0003, 64'h8000_0000, 64'h8000_0007,
                                    64'h8000_0004, 64'h8000_0002, 64'h8000_0002, 64'h8000_0000,
                                    64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
      logic [63:0] exp_t [0:10] = '{64'hFFFF_FFFF_FFFF_FF89, 64'h0000_0000_0000_0089,
                                    64'hFFFF_FFFF_FFFF_FFEF, 64'h0000_0000_0000_0001,
                                    64'h0000_0000_0000_4567, 64'hFFFF_FFFF_FFFF_89AB,
                                    64'h0000_0000_0000_89AB, 64'hFFFF_FFFF_89AB_CDEF,
                                    64'h0000_0000_89AB_CDEF, 64'h0000_0000_0123_4567,
                                    64'h0123_4567_89AB_CDEF};
      logic [63:0] exp_addr;
      for (int i = 0; i < 11; i++) begin
         issue(1'b0, op_t[i], adr_t[i], 64'h0, 0, 64'h0123_4567_89AB_CDEF, 1'b0);
         exp_addr = adr_t[i] & ~64'h7;
         checks++; if (g_rdata !== exp_t[i]) begin errors++; $display("FAIL load_data[%0d] got %h exp %h", i, g_rdata, exp_t[i]); end
         checks++; if (g_resp_cyc != 3 || g_misalign !== 1'b0 || g_err !== 1'b0) begin errors++; $display("FAIL load_resp[%0d] got cyc %0d mis %b err %b exp 3 0 0", i, g_resp_cyc, g_misalign, g_err); end
         checks++; if (g_addr !== exp_addr || g_wstrb !== 8'h00) begin errors++; $display("FAIL load_bus[%0d] got %h/%h exp %h/00", i, g_addr, g_wstrb, exp_addr); end
      end
   endtask

   task automatic test_store_lanes();
      logic [2:0]  op_t  [0:3] = '{MEMOP_SH, MEMOP_SB, MEMOP_SW, MEMOP_SB};
      logic [63:0] adr_t [0:3] = '{64'h8000_0006, 64'h8000_0005, 64'h8000_0004, 64'h8000_0000};
      logic [63:0] wd_t  [0:3] = '{64'hBEEF, 64'hAA, 64'h1234_5678, 64'h5A};
      logic [7:0]  stb_t [0:3] = '{8'hC0, 8'h20, 8'hF0, 8'h01};
      logic [63:0] ewd_t [0:3] = '{64'hBEEF_0000_0000_0000, 64'h0000_AA00_0000_0000,
                                   64'h1234_5678_0000_0000, 64'h0000_0000_0000_005A};
      for (int i = 0; i < 4; i++) begin
         issue(1'b1, op_t[i], adr_t[i], wd_t[i], 0, 64'hFFFF_0000_FFFF_0000, 1'b0);
         checks++; if (g_addr !== 64'h8000_0000) begin errors++; $display("FAIL store_addr[%0d] got %h exp 80000000", i, g_addr); end
         checks++; if (g_wstrb !== stb_t[i]) begin errors++; $display("FAIL store_wstrb[%0d] got %h exp %h", i, g_wstrb, stb_t[i]); end
         checks++; if (g_wdata !== ewd_t[i]) begin errors++; $display("FAIL store_wdata[%0d] got %h exp %h", i, g_wdata, ewd_t[i]); end
         checks++; if (g_rdata !== 64'h0 || g_resp_cyc != 3) begin errors++; $display("FAIL store_resp[%0d] got %h cyc %0d exp 0 cyc 3", i, g_rdata, g_resp_cyc); end
      end
   endtask

   task automatic test_misalign();
      logic        we_t  [0:6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [2:0]  op_t  [0:6] = '{MEMOP_LW, MEMOP_LH, MEMOP_LD, MEMOP_SD, MEMOP_SW, 3'b100, 3'b111};
      logic [63:0] adr_t [0:6] = '{64'h8000_0002, 64'h8000_0001, 64'h8000_0004, 64'h8000_0003,
                                   64'h8000_0006, 64'h8000_0000, 64'h8000_0000};
      for (int i = 0; i < 7; i++) begin
         issue(we_t[i], op_t[i], adr_t[i], 64'h55, 0, 64'h0123_4567_89AB_CDEF, 1'b0);
         checks++; if (g_resp_cyc != 1) begin errors++; $display("FAIL mis_latency[%0d] got %0d exp 1", i, g_resp_cyc); end
         checks++; if (g_seen !== 1'b0) begin errors++; $display("FAIL mis_no_bus[%0d] got %b exp 0", i, g_seen); end
         checks++; if (g_misalign !== 1'b1 || g_err !== 1'b0) begin errors++; $display("FAIL mis_flags[%0d] got mis %b err %b exp 1 0", i, g_misalign, g_err); end
         checks++; if (g_rdata !== 64'h0) begin errors++; $display("FAIL mis_rdata[%0d] got %h exp 0", i, g_rdata); end
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      seen = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_memop = MEMOP_LD;
      req_addr = 64'h8000_0008; req_wdata = '0;
      bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = 64'h1111_2222_3333_4444; bus.mem_resp_err = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      #1;
      checks++; if (stall_o !== 1'b1 || bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_wait got stall %b mreq %b exp 1 0", stall_o, bus.mem_req_valid); end
      rst_n = 1'b0; req_valid = 1'b0;
      #1;
      checks++; if (stall_o !== 1'b0 || bus.mem_req_valid !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_drop got stall %b mreq %b resp %b exp 0 0 0", stall_o, bus.mem_req_valid, resp_valid); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", req_ready); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #2;
         if (resp_valid) seen = 1'b1;
         @(posedge clk); #1;
         bus.mem_resp_valid = 1'b0;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_late_resp got %b exp 0", seen); end
      checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL rmid_rdata got %h exp 0", resp_rdata); end
   endtask

   initial begin
      test_reset();
      test_store_sd();
      test_err_wait();
      test_load_ext();
      test_store_lanes();
      test_misalign();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Memory-side controller for the load/store stage; replaces the direct DPI memory access with a handshaked 64-bit data bus.
- Accepts one load/store request per instruction from the LS stage and stalls the pipeline while the bus transaction is outstanding.
- Generates byte-lane data and strobes for stores; returns sign- or zero-extended load results to LS/WB.
- Sits directly downstream of the LS stage, between it and the data memory (or a future D-cache).

Parameters:
- XLEN, 64, data and address width.
- STRB_W, 8, write-strobe width (XLEN/8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  LS stage presents a load or store this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_memop  in  3  funct3: b/h/w/d, plus the unsigned load variants.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- req_ready  out  1  controller idle; request is accepted this cycle.
- stall_o  out  1  hold IF..LS pipeline registers.
- resp_valid  out  1  one-cycle pulse; operation complete.
- resp_rdata  out  XLEN  extended load result; 0 for stores and errors.
- misalign_o  out  1  valid with resp_valid: misaligned address or illegal memop.
- err_o  out  1  valid with resp_valid: bus error.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts request.
- mem_req_we  out  1  bus write.
- mem_req_addr  out  XLEN  req_addr with bits [2:0] cleared.
- mem_req_wdata  out  XLEN  lane-shifted store data.
- mem_req_wstrb  out  STRB_W  byte enables (0 for loads).
- mem_resp_valid  in  1  bus response.
- mem_resp_rdata  in  XLEN  aligned 8-byte read data.
- mem_resp_err  in  1  bus error, qualified by mem_resp_valid.

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset (asynchronous, active-low): state = IDLE, all registered outputs and latched fields = 0.
  - req_ready = 1 while in reset (combinational, state == IDLE).
  - Reset mid-transaction abandons the bus operation. Responses arriving afterwards in IDLE are ignored.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we/memop/addr/wdata.
  - Aligned, legal request -> REQ.
  - Misaligned or illegal request -> RESP with misalign_o = 1; no bus request is issued.
- Alignment rules:
  - h: addr[0] == 0.
  - w: addr[1:0] == 0.
  - d: addr[2:0] == 0.
- Illegal memops:
  - Loads: funct3 = 111.
  - Stores: funct3 >= 100.
- REQ:
  - mem_req_valid = 1, with we/addr/wdata/wstrb held stable from latched values until mem_req_ready.
  - On mem_req_ready -> WAIT.
- WAIT:
  - mem_resp_valid is only honoured here, so the earliest response is the cycle after acceptance.
  - On mem_resp_valid, latch the extended data (or the error) -> RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle; stall_o = 0; req_ready = 0, so the still-present request is never re-accepted.
  - Then -> IDLE.
- stall_o = (IDLE & req_valid) | REQ | WAIT.
  - The pipeline advances on the RESP edge.
- Latency (from the IDLE accept cycle T):
  - Zero-wait bus: REQ T+1, WAIT T+2, RESP T+3.
  - Misaligned: RESP at T+1.
- Store lanes, with off = addr[2:0]:
  - wstrb = base << off, where base is sb 0x01, sh 0x03, sw 0x0F, sd 0xFF.
  - wdata = req_wdata << (8*off).
- Load extraction:
  - Shift rdata right by 8*off, then truncate to the access size.
  - lb/lh/lw sign-extend to XLEN; lbu/lhu/lwu zero-extend; ld passes through.
- Error response: resp_rdata = 0, err_o = 1.
- Store response: resp_rdata = 0.
- resp_rdata, misalign_o and err_o hold their value until the next RESP; they are only meaningful with resp_valid.

Decomposition:
- Shared package / defines.v:
  - FSM state encoding.
  - Existing memop constants (`lb..`sd).
  - Base strobe masks.
  - Alignment-check function.
- One combinational sub-module, lsu_lane_align:
  - Store path: shift and strobe generation.
  - Load path: extract and extend.
  - Misalignment/illegal detection.

Test Plan:
- sd addr 0x8000_0010, wdata 0x1122334455667788, zero-wait bus -> mem_req_addr 0x8000_0010, wstrb 0xFF, wdata unchanged; stall_o high T..T+2; resp_valid at T+3, rdata 0.
- lb then lbu at 0x8000_0003, mem rdata 0x0123456789ABCDEF -> resp_rdata 0xFFFFFFFFFFFFFF89, then 0x0000000000000089.
- sh addr 0x8000_0006, wdata 0xBEEF -> mem_req_addr 0x8000_0000, wstrb 0xC0, wdata 0xBEEF000000000000.
- lw addr 0x8000_0002 -> no mem_req_valid; resp_valid + misalign_o at T+1; rdata 0.
- ld with mem_req_ready low for 5 cycles, then resp with mem_resp_err -> request fields stable throughout; resp_valid + err_o; rdata 0; stall held until RESP.
- rst_n low during WAIT -> stall_o/mem_req_valid/resp_valid drop immediately; a later mem_resp_valid does not produce resp_valid.
